// File: rtl/button_ctrl_pkg.sv
// Shared constants for the push-button interrupt controller.
package button_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_DIR     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE    = 2'd3;

  // 1 ms at 50 MHz
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/button_debounce.sv
// One button bit: two-flop synchroniser, polarity normalisation and a
// stability counter that only accepts a level held for DEBOUNCE_CYCLES cycles.
module button_debounce
  import button_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic stable
);

  logic [1:0]       sync_q;
  logic             sync;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  // Raw flops reset to the released pin level so sync is 0 out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= {2{ACTIVE_LOW}};
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], pin};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign sync = sync_q[1] ^ ACTIVE_LOW;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = sync;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/button_irq_ctrl.sv
// Avalon-MM push-button port: debounced data, per-bit press capture with
// write-1-to-clear, interrupt mask and a registered level IRQ.
module button_irq_ctrl
  import button_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_prev_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .pin    (in_port[i]),
      .stable (stable[i])
    );
  end

  assign unused_wdata = ^writedata;
  assign wr_en        = chipselect & ~write_n;
  assign rise         = stable & ~stable_prev_q;

  always_comb begin
    mask_d = mask_q;
    clr    = '0;
    if (wr_en && address == ADDR_IRQMASK) mask_d = writedata[WIDTH-1:0];
    if (wr_en && address == ADDR_EDGE)    clr    = writedata[WIDTH-1:0];
    // A press arriving with a clear of the same bit keeps the bit set.
    edge_d = (edge_q & ~clr) | rise;
    irq_d  = |(edge_d & mask_d);
  end

  always_comb begin
    rdata_d = '0;
    unique case (address)
      ADDR_DATA:    rdata_d[WIDTH-1:0] = stable;
      ADDR_DIR:     rdata_d            = '0;
      ADDR_IRQMASK: rdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE:    rdata_d[WIDTH-1:0] = edge_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_prev_q <= '0;
      mask_q        <= '0;
      edge_q        <= '0;
      rdata_q       <= '0;
      irq_q         <= 1'b0;
    end else begin
      stable_prev_q <= stable;
      mask_q        <= mask_d;
      edge_q        <= edge_d;
      rdata_q       <= rdata_d;
      irq_q         <= irq_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_q;

endmodule
